// File: rtl/axi_lite_slv.sv
// rtl/axi_lite_slv.sv - AXI4-Lite responder bridging one port to an SRAM-style peripheral bus
module axi_lite_slv #(
  parameter int          MEM_AW = 10,
  parameter logic [31:0] BASE   = 32'h2000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_awaddr,
  input  logic [2:0]        s_awprot,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [31:0]       s_araddr,
  input  logic [2:0]        s_arprot,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              per_en_o,
  output logic              per_we_o,
  output logic [MEM_AW-1:0] per_addr_o,
  output logic [31:0]       per_wdata_o,
  output logic [3:0]        per_wem_o,
  input  logic [31:0]       per_rdata_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WCOL  = 3'd1,
    WACC  = 3'd2,
    WRESP = 3'd3,
    RACC  = 3'd4,
    RWAIT = 3'd5,
    RRESP = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic        aw_got;
  logic        w_got;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] araddr_q;
  logic        accept_phase;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        wr_in_range;
  logic        rd_in_range;
  logic        unused_bits;

  // Protection bits carry no meaning here and byte offsets within a word are dropped.
  assign unused_bits = ^{s_awprot, s_arprot, awaddr_q[1:0], araddr_q[1:0]};

  // Readies depend only on state and capture flags so they never combinationally follow a valid,
  // except arready, which must yield to any pending write.
  assign accept_phase = (state == IDLE) || (state == WCOL);
  assign s_awready    = accept_phase & ~aw_got;
  assign s_wready     = accept_phase & ~w_got;
  assign s_arready    = (state == IDLE) & ~s_awvalid & ~s_wvalid;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // The window is aligned to its size, so a tag compare on the upper bits decides decode.
  assign wr_in_range = (awaddr_q[31:MEM_AW+2] == BASE[31:MEM_AW+2]);
  assign rd_in_range = (araddr_q[31:MEM_AW+2] == BASE[31:MEM_AW+2]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: write collection has priority, then single-cycle access, then response.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, WCOL: begin
        if ((aw_got | aw_hs) && (w_got | w_hs)) begin
          state_nxt = WACC;
        end else if (aw_got | aw_hs | w_got | w_hs) begin
          state_nxt = WCOL;
        end else if (ar_hs) begin
          state_nxt = RACC;
        end
      end
      WACC:    state_nxt = WRESP;
      WRESP:   if (s_bready) state_nxt = IDLE;
      RACC:    state_nxt = RWAIT;
      RWAIT:   state_nxt = RRESP;
      RRESP:   if (s_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture address/data on each handshake and sample the peripheral read data one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      araddr_q <= '0;
      s_rdata  <= '0;
    end else begin
      if (aw_hs) begin
        aw_got   <= 1'b1;
        awaddr_q <= s_awaddr;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (ar_hs) begin
        araddr_q <= s_araddr;
      end
      if ((state == WRESP) && s_bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (state == RWAIT) begin
        s_rdata <= rd_in_range ? per_rdata_i : 32'h0;
      end
    end
  end

  // Output decode: peripheral strobe only in the access states, responses only in the response states.
  always_comb begin
    per_en_o    = 1'b0;
    per_we_o    = 1'b0;
    per_addr_o  = '0;
    per_wdata_o = '0;
    per_wem_o   = '0;
    s_bvalid    = 1'b0;
    s_bresp     = RESP_OKAY;
    s_rvalid    = 1'b0;
    s_rresp     = RESP_OKAY;
    unique case (state)
      WACC: begin
        per_en_o    = wr_in_range;
        per_we_o    = wr_in_range;
        per_addr_o  = awaddr_q[MEM_AW+1:2];
        per_wdata_o = wdata_q;
        per_wem_o   = wstrb_q;
      end
      WRESP: begin
        s_bvalid = 1'b1;
        s_bresp  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      RACC: begin
        per_en_o   = rd_in_range;
        per_addr_o = araddr_q[MEM_AW+1:2];
      end
      RRESP: begin
        s_rvalid = 1'b1;
        s_rresp  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_slv.sv
// tb/tb_axi_lite_slv.sv - scoreboard bench for axi_lite_slv with a behavioural memory model
module tb_axi_lite_slv;

  localparam int          MEM_AW = 10;
  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam int          WORDS  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       s_awaddr = '0;
  logic [2:0]        s_awprot = '0;
  logic              s_awvalid = 1'b0;
  logic              s_awready;
  logic [31:0]       s_wdata = '0;
  logic [3:0]        s_wstrb = '0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready = 1'b0;
  logic [31:0]       s_araddr = '0;
  logic [2:0]        s_arprot = '0;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready = 1'b0;
  logic              per_en_o;
  logic              per_we_o;
  logic [MEM_AW-1:0] per_addr_o;
  logic [31:0]       per_wdata_o;
  logic [3:0]        per_wem_o;
  logic [31:0]       per_rdata_i = '0;

  axi_lite_slv #(.MEM_AW(MEM_AW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .per_en_o(per_en_o), .per_we_o(per_we_o), .per_addr_o(per_addr_o),
    .per_wdata_o(per_wdata_o), .per_wem_o(per_wem_o), .per_rdata_i(per_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int per_en_cnt = 0;
  int last_per_en_cyc = -100;
  int last_b_hs = -100;
  int last_ar_hs = -100;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wem;
  } pexp_t;

  logic [1:0]  b_q[$];
  rexp_t       r_q[$];
  pexp_t       p_q[$];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] per_mem [WORDS];

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < (32'd4 << MEM_AW);
  endfunction

  function automatic logic [MEM_AW-1:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[MEM_AW+1:2];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Peripheral model: word memory with byte mask, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (per_en_o === 1'b1) begin
      if (per_we_o) per_mem[per_addr_o] <= merge(per_mem[per_addr_o], per_wdata_o, per_wem_o);
      else          per_rdata_i <= per_mem[per_addr_o];
    end
  end

  // Monitor: compares every presented response and peripheral strobe against the scoreboard.
  always @(negedge clk) begin
    if (!rst && cyc > 0) begin
      if (s_bvalid && s_rvalid) chk_eq("b_r_exclusive", {s_bvalid, s_rvalid}, 2'b00);
      if (s_awvalid || s_wvalid) chk_eq("arready_write_priority", s_arready, 1'b0);
      if (s_bvalid) begin
        chk_eq("b_expected", b_q.size(), 1);
        if (b_q.size() > 0) begin
          chk_eq("bresp", s_bresp, b_q[0]);
          if (s_bready) void'(b_q.pop_front());
        end
      end
      if (s_rvalid) begin
        chk_eq("r_expected", r_q.size(), 1);
        if (r_q.size() > 0) begin
          chk_eq("rresp", s_rresp, r_q[0].resp);
          chk_eq("rdata", s_rdata, r_q[0].data);
          if (s_rready) void'(r_q.pop_front());
        end
      end
      if (per_en_o === 1'b1) begin
        per_en_cnt++;
        last_per_en_cyc = cyc;
        chk_eq("per_expected", p_q.size() > 0, 1);
        if (p_q.size() > 0) begin
          chk_eq("per_we", per_we_o, p_q[0].we);
          chk_eq("per_addr", per_addr_o, p_q[0].addr);
          if (p_q[0].we) begin
            chk_eq("per_wdata", per_wdata_o, p_q[0].wdata);
            chk_eq("per_wem", per_wem_o, p_q[0].wem);
          end
          void'(p_q.pop_front());
        end
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int aw_dly, input int w_dly, input int b_dly, input bit rst_in_resp);
    bit   aw_done = 0;
    bit   w_done = 0;
    bit   got = 0;
    int   hs = -100;
    int   first = -1;
    int   t = 0;
    int   cnt0;
    logic ok;
    ok   = in_rng(addr);
    cnt0 = per_en_cnt;
    b_q.push_back(ok ? 2'b00 : 2'b10);
    if (ok) begin
      p_q.push_back('{1'b1, widx(addr), data, strb});
      ref_mem[widx(addr)] = merge(ref_mem[widx(addr)], data, strb);
    end
    s_awaddr = addr;
    s_wdata  = data;
    s_wstrb  = strb;
    if (b_dly < 0) s_bready = 1'b1;
    while (!(aw_done && w_done) && t < 64) begin
      @(posedge clk); #1;
      s_awvalid = !aw_done && (t >= aw_dly);
      s_wvalid  = !w_done && (t >= w_dly);
      @(negedge clk);
      if (w_done && !aw_done) begin
        chk_eq("wready_after_w", s_wready, 1'b0);
        chk_eq("awready_waiting", s_awready, 1'b1);
      end
      if (aw_done && !w_done) begin
        chk_eq("awready_after_aw", s_awready, 1'b0);
        chk_eq("wready_waiting", s_wready, 1'b1);
      end
      if (s_awvalid && s_awready) begin aw_done = 1; hs = cyc; end
      if (s_wvalid && s_wready) begin w_done = 1; hs = cyc; end
      t++;
    end
    chk_eq("wr_handshake", aw_done && w_done, 1'b1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    t = 0;
    while (!got && t < 64) begin
      @(negedge clk);
      if (s_bvalid) begin
        if (first < 0) begin
          first = cyc;
          chk_eq("b_latency", first - hs, 2);
        end
        if (s_bready) begin got = 1; last_b_hs = cyc; end
      end
      if (rst_in_resp && first >= 0) break;
      @(posedge clk); #1;
      if (got) s_bready = 1'b0;
      else if (b_dly >= 0 && first >= 0 && cyc - first > b_dly) s_bready = 1'b1;
      t++;
    end
    chk_eq("wr_per_en_count", per_en_cnt - cnt0, ok ? 1 : 0);
    if (ok) chk_eq("wr_per_en_latency", last_per_en_cyc - hs, 1);
    if (rst_in_resp) begin
      chk_eq("bvalid_before_rst", first >= 0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      if (b_q.size() > 0) void'(b_q.pop_front());
      @(negedge clk);
      chk_eq("rst_bvalid", s_bvalid, 1'b0);
      chk_eq("rst_awready", s_awready, 1'b1);
      chk_eq("rst_wready", s_wready, 1'b1);
      chk_eq("rst_arready", s_arready, 1'b1);
      chk_eq("rst_per_en", per_en_o, 1'b0);
    end else begin
      chk_eq("bvalid_seen", got, 1'b1);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input int ar_dly, input int r_dly);
    bit   done = 0;
    bit   got = 0;
    int   hs = -100;
    int   first = -1;
    int   t = 0;
    int   cnt0 = 0;
    logic ok;
    ok = in_rng(addr);
    s_araddr = addr;
    if (r_dly < 0) s_rready = 1'b1;
    while (!done && t < 64) begin
      @(posedge clk); #1;
      s_arvalid = (t >= ar_dly);
      @(negedge clk);
      if (s_arvalid && s_arready) begin
        done = 1;
        hs = cyc;
        last_ar_hs = cyc;
        cnt0 = per_en_cnt;
        r_q.push_back('{ok ? ref_mem[widx(addr)] : 32'h0, ok ? 2'b00 : 2'b10});
        if (ok) p_q.push_back('{1'b0, widx(addr), 32'h0, 4'h0});
      end
      t++;
    end
    chk_eq("ar_handshake", done, 1'b1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    t = 0;
    while (!got && t < 64) begin
      @(negedge clk);
      if (s_rvalid) begin
        if (first < 0) begin
          first = cyc;
          chk_eq("r_latency", first - hs, 3);
        end
        if (s_rready) got = 1;
      end
      @(posedge clk); #1;
      if (got) s_rready = 1'b0;
      else if (r_dly >= 0 && first >= 0 && cyc - first > r_dly) s_rready = 1'b1;
      t++;
    end
    chk_eq("rvalid_seen", got, 1'b1);
    chk_eq("rd_per_en_count", per_en_cnt - cnt0, ok ? 1 : 0);
    if (ok) chk_eq("rd_per_en_latency", last_per_en_cyc - hs, 1);
    @(negedge clk);
    chk_eq("rvalid_after_rready", s_rvalid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ref_mem[i] = 32'h0;
      per_mem[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("reset_bvalid", s_bvalid, 1'b0);
    chk_eq("reset_rvalid", s_rvalid, 1'b0);
    chk_eq("reset_bresp", s_bresp, 2'b00);
    chk_eq("reset_rresp", s_rresp, 2'b00);
    chk_eq("reset_rdata", s_rdata, 32'h0);
    chk_eq("reset_per_en", per_en_o, 1'b0);
    chk_eq("reset_per_we", per_we_o, 1'b0);
    chk_eq("reset_readies", {s_awready, s_wready, s_arready}, 3'b111);

    wr(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, -1, 1'b0);
    wr(BASE + 32'h20, 32'h12345678, 4'h3, 3, 0, 0, 1'b0);
    wr(BASE + 32'h24, 32'hA5A5A5A5, 4'hF, 0, 2, 2, 1'b0);
    wr(BASE + 32'h24, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 1'b0);
    rd(BASE + 32'h10, 0, 3);
    rd(BASE + 32'h22, 0, -1);
    rd(BASE + 32'h24, 1, 0);
    wr(BASE + (32'd4 << MEM_AW), 32'h11111111, 4'hF, 0, 0, 1, 1'b0);
    rd(32'h0000_0000, 0, 1);

    s_araddr = BASE + 32'h40;
    fork
      wr(BASE + 32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 1, 1'b0);
      rd(BASE + 32'h40, 0, 0);
    join
    chk_eq("ar_after_b", last_ar_hs - last_b_hs, 1);

    wr(BASE + 32'h50, 32'h0BADF00D, 4'hF, 0, 0, 20, 1'b1);
    rd(BASE + 32'h50, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      else if (sel == 8) a = BASE + (32'd4 << MEM_AW) + ($urandom_range(0, 63) << 2);
      else               a = $urandom;
      if ($urandom_range(0, 1) == 1)
        wr(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 4)) - 1, 1'b0);
      else
        rd(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)) - 1);
    end

    repeat (4) @(negedge clk);
    chk_eq("b_queue_drained", b_q.size(), 0);
    chk_eq("r_queue_drained", r_q.size(), 0);
    chk_eq("p_queue_drained", p_q.size(), 0);
    for (int i = 0; i < 24; i++) chk_eq("per_mem_final", per_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
